// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command codes, responses, FSM states and status bit map shared by the command handler.
package uart_cmd_pkg;
  localparam logic [7:0] CMD_WR_DELAY   = 8'h64;
  localparam logic [7:0] CMD_WR_WIDTH   = 8'h77;
  localparam logic [7:0] CMD_WR_PULSES  = 8'h6E;
  localparam logic [7:0] CMD_WR_SPACING = 8'h73;
  localparam logic [7:0] CMD_RD_DELAY   = 8'h44;
  localparam logic [7:0] CMD_RD_WIDTH   = 8'h57;
  localparam logic [7:0] CMD_RD_PULSES  = 8'h4E;
  localparam logic [7:0] CMD_RD_SPACING = 8'h53;
  localparam logic [7:0] CMD_ARM        = 8'h61;
  localparam logic [7:0] CMD_DISARM     = 8'h78;
  localparam logic [7:0] CMD_FIRE       = 8'h67;
  localparam logic [7:0] CMD_STATUS     = 8'h71;
  localparam logic [7:0] RSP_ACK        = 8'h6B;
  localparam logic [7:0] RSP_NAK        = 8'h3F;
  typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_RESP, S_READ, S_TX_WAIT} state_e;
  localparam int ST_PULSE_EN = 0;
  localparam int ST_TIMEOUT  = 1;
  localparam int ST_OVERRUN  = 2;
endpackage

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: serialises a 1-4 byte response MSB first under the transmitter busy handshake.
module uart_resp_tx
  import uart_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  count_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_en_o,
  output logic        busy_o
);
  state_e      st_q, st_d;
  logic [31:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;
  always_comb begin
    st_d      = st_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    case (st_q)
      S_IDLE: if (start_i) begin
        sh_d  = data_i << {3'd4 - count_i, 3'b0};
        cnt_d = count_i;
        st_d  = (count_i == 3'd1) ? S_RESP : S_READ;
      end
      S_RESP, S_READ: if (!tx_busy_i) begin
        tx_en_d   = 1'b1;
        tx_data_d = sh_q[31:24];
        sh_d      = sh_q << 8;
        cnt_d     = cnt_q - 1'b1;
        st_d      = S_TX_WAIT;
      end
      // busy only rises the cycle after tx_en, so skip one cycle before looking at it
      S_TX_WAIT: st_d = (cnt_q == 3'd0) ? S_IDLE : S_READ;
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q      <= S_IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
    end
  assign tx_data_o = tx_data_q;
  assign tx_en_o   = tx_en_q;
  assign busy_o    = st_q != S_IDLE;
endmodule

// File: rtl/uart_cmd_handler.sv
// uart_cmd_handler: decodes UART command bytes into glitch configuration, arm/fire control and responses.
module uart_cmd_handler
  import uart_cmd_pkg::*;
#(
  parameter int DELAY_W        = 16,
  parameter int WIDTH_W        = 8,
  parameter int PULSES_W       = 8,
  parameter int SPACING_W      = 16,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_en_o,
  input  logic                 tx_busy_i,
  output logic [DELAY_W-1:0]   delay_o,
  output logic [WIDTH_W-1:0]   width_o,
  output logic [PULSES_W-1:0]  num_pulses_o,
  output logic [SPACING_W-1:0] pulse_spacing_o,
  output logic                 pulse_en_o,
  output logic                 trigger_o
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] DELAY_B   = 3'(DELAY_W / 8);
  localparam logic [2:0] WIDTH_B   = 3'(WIDTH_W / 8);
  localparam logic [2:0] PULSES_B  = 3'(PULSES_W / 8);
  localparam logic [2:0] SPACING_B = 3'(SPACING_W / 8);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  state_e               state_q, state_d;
  logic [1:0]           tgt_q, tgt_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [23:0]          pay_q, pay_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [PULSES_W-1:0]  pulses_q, pulses_d;
  logic [SPACING_W-1:0] spacing_q, spacing_d;
  logic                 pulse_en_q, pulse_en_d;
  logic                 trigger_q, trigger_d;
  logic                 ovr_q, ovr_d;
  logic                 tflag_q, tflag_d;
  logic                 start, ser_busy;
  logic [31:0]          rsp_data, wr_word;
  logic [2:0]           rsp_cnt;
  logic [7:0]           status;
  assign wr_word = {pay_q, rx_data_i};
  always_comb begin
    status              = '0;
    status[ST_PULSE_EN] = pulse_en_q;
    status[ST_TIMEOUT]  = tflag_q;
    status[ST_OVERRUN]  = ovr_q;
  end
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    pay_d      = pay_q;
    tmo_d      = '0;
    delay_d    = delay_q;
    width_d    = width_q;
    pulses_d   = pulses_q;
    spacing_d  = spacing_q;
    pulse_en_d = pulse_en_q;
    trigger_d  = 1'b0;
    ovr_d      = ovr_q;
    tflag_d    = tflag_q;
    start      = 1'b0;
    rsp_data   = {24'd0, RSP_NAK};
    rsp_cnt    = 3'd1;
    case (state_q)
      S_IDLE: if (rx_valid_i) begin
        if (ser_busy) ovr_d = 1'b1;
        else begin
          start = 1'b1;
          case (rx_data_i)
            CMD_WR_DELAY:   begin start = 1'b0; tgt_d = 2'd0; cnt_d = DELAY_B;   state_d = S_PAYLOAD; end
            CMD_WR_WIDTH:   begin start = 1'b0; tgt_d = 2'd1; cnt_d = WIDTH_B;   state_d = S_PAYLOAD; end
            CMD_WR_PULSES:  begin start = 1'b0; tgt_d = 2'd2; cnt_d = PULSES_B;  state_d = S_PAYLOAD; end
            CMD_WR_SPACING: begin start = 1'b0; tgt_d = 2'd3; cnt_d = SPACING_B; state_d = S_PAYLOAD; end
            CMD_RD_DELAY:   begin rsp_data = 32'(delay_q);   rsp_cnt = DELAY_B;   end
            CMD_RD_WIDTH:   begin rsp_data = 32'(width_q);   rsp_cnt = WIDTH_B;   end
            CMD_RD_PULSES:  begin rsp_data = 32'(pulses_q);  rsp_cnt = PULSES_B;  end
            CMD_RD_SPACING: begin rsp_data = 32'(spacing_q); rsp_cnt = SPACING_B; end
            CMD_ARM:        begin pulse_en_d = 1'b1; rsp_data = {24'd0, RSP_ACK}; end
            CMD_DISARM:     begin pulse_en_d = 1'b0; rsp_data = {24'd0, RSP_ACK}; end
            CMD_FIRE: begin
              trigger_d = pulse_en_q;
              rsp_data  = {24'd0, pulse_en_q ? RSP_ACK : RSP_NAK};
            end
            CMD_STATUS: begin rsp_data = {24'd0, status}; ovr_d = 1'b0; tflag_d = 1'b0; end
            default: ;
          endcase
        end
      end
      S_PAYLOAD: if (rx_valid_i) begin
        pay_d = wr_word[23:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 3'd1) begin
          delay_d   = (tgt_q == 2'd0) ? DELAY_W'(wr_word)   : delay_q;
          width_d   = (tgt_q == 2'd1) ? WIDTH_W'(wr_word)   : width_q;
          pulses_d  = (tgt_q == 2'd2) ? PULSES_W'(wr_word)  : pulses_q;
          spacing_d = (tgt_q == 2'd3) ? SPACING_W'(wr_word) : spacing_q;
          start     = 1'b1;
          rsp_data  = {24'd0, RSP_ACK};
          state_d   = S_IDLE;
        end
      end else if (tmo_q == TMO_LAST) begin
        tflag_d = 1'b1;
        start   = 1'b1;
        state_d = S_IDLE;
      end else tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      cnt_q      <= '0;
      pay_q      <= '0;
      tmo_q      <= '0;
      delay_q    <= '0;
      width_q    <= '0;
      pulses_q   <= '0;
      spacing_q  <= '0;
      pulse_en_q <= 1'b0;
      trigger_q  <= 1'b0;
      ovr_q      <= 1'b0;
      tflag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      pay_q      <= pay_d;
      tmo_q      <= tmo_d;
      delay_q    <= delay_d;
      width_q    <= width_d;
      pulses_q   <= pulses_d;
      spacing_q  <= spacing_d;
      pulse_en_q <= pulse_en_d;
      trigger_q  <= trigger_d;
      ovr_q      <= ovr_d;
      tflag_q    <= tflag_d;
    end
  uart_resp_tx u_resp_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .data_i   (rsp_data),
    .count_i  (rsp_cnt),
    .tx_busy_i(tx_busy_i),
    .tx_data_o(tx_data_o),
    .tx_en_o  (tx_en_o),
    .busy_o   (ser_busy)
  );
  assign delay_o         = delay_q;
  assign width_o         = width_q;
  assign num_pulses_o    = pulses_q;
  assign pulse_spacing_o = spacing_q;
  assign pulse_en_o      = pulse_en_q;
  assign trigger_o       = trigger_q;
endmodule

// File: tb/tb_uart_cmd_handler.sv
// tb_uart_cmd_handler: directed command sequences against a 16-bit-delay and a 32-bit-delay handler.
module tb_uart_cmd_handler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data0 = '0, rx_data1 = '0;
  logic        rx_valid0 = 1'b0, rx_valid1 = 1'b0;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_en0, tx_en1, tx_busy0, tx_busy1;
  logic        hold0 = 1'b0;
  int          bc0 = 0, bc1 = 0, trig_cnt = 0;
  logic [15:0] delay0;
  logic [31:0] delay1;
  logic [7:0]  width0, pulses0, width1, pulses1;
  logic [15:0] spacing0, spacing1;
  logic        pen0, pen1, trig0, trig1;
  logic [7:0]  q0[$], q1[$];
  int          n_tests = 0, n_fail = 0, t0;
  always #5 clk = ~clk;
  assign tx_busy0 = hold0 | (bc0 != 0);
  assign tx_busy1 = bc1 != 0;
  uart_cmd_handler #(.TIMEOUT_CYCLES(40)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data0), .rx_valid_i(rx_valid0),
    .tx_data_o(tx_data0), .tx_en_o(tx_en0), .tx_busy_i(tx_busy0),
    .delay_o(delay0), .width_o(width0), .num_pulses_o(pulses0),
    .pulse_spacing_o(spacing0), .pulse_en_o(pen0), .trigger_o(trig0)
  );
  uart_cmd_handler #(.DELAY_W(32), .TIMEOUT_CYCLES(40)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data1), .rx_valid_i(rx_valid1),
    .tx_data_o(tx_data1), .tx_en_o(tx_en1), .tx_busy_i(tx_busy1),
    .delay_o(delay1), .width_o(width1), .num_pulses_o(pulses1),
    .pulse_spacing_o(spacing1), .pulse_en_o(pen1), .trigger_o(trig1)
  );
  // transmitter model: capture each byte, then stay busy for a few cycles
  always @(negedge clk) begin
    if (tx_en0) q0.push_back(tx_data0);
    if (tx_en1) q1.push_back(tx_data1);
    bc0 <= tx_en0 ? 4 : (bc0 != 0 ? bc0 - 1 : 0);
    bc1 <= tx_en1 ? 4 : (bc1 != 0 ? bc1 - 1 : 0);
    trig_cnt <= trig_cnt + (trig0 ? 1 : 0);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input int sel, input logic [7:0] b);
    @(negedge clk);
    if (sel == 0) begin rx_data0 = b; rx_valid0 = 1'b1; end
    else begin rx_data1 = b; rx_valid1 = 1'b1; end
    @(negedge clk);
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
  endtask
  task automatic expect_tx(input int sel, input string tag, input logic [7:0] exp);
    int n = 0;
    while (((sel == 0) ? q0.size() : q1.size()) == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (((sel == 0) ? q0.size() : q1.size()) == 0) check(tag, 32'hFFFF_FFFF, {24'd0, exp});
    else check(tag, {24'd0, (sel == 0) ? q0.pop_front() : q1.pop_front()}, {24'd0, exp});
  endtask
  task automatic settle();
    repeat (12) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_delay", {16'd0, delay0}, 32'd0);
    check("rst_cfg", {width0, pulses0, spacing0}, 32'd0);
    check("rst_ctl", {29'd0, pen0, trig0, tx_en0}, 32'd0);
    check("rst_txd", {24'd0, tx_data0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h64); send(0, 8'h12);
    check("partial_wr", {16'd0, delay0}, 32'd0);
    send(0, 8'h34);
    check("delay_commit", {16'd0, delay0}, 32'h1234);
    expect_tx(0, "wr_d_ack", 8'h6B);
    settle();
    send(0, 8'h44);
    expect_tx(0, "rd_d_b0", 8'h12);
    expect_tx(0, "rd_d_b1", 8'h34);
    settle();
    send(0, 8'h77); send(0, 8'h5A); expect_tx(0, "wr_w_ack", 8'h6B); settle();
    send(0, 8'h6E); send(0, 8'h03); expect_tx(0, "wr_n_ack", 8'h6B); settle();
    send(0, 8'h73); send(0, 8'h01); send(0, 8'h00); expect_tx(0, "wr_s_ack", 8'h6B); settle();
    check("cfg_after_wr", {width0, pulses0, spacing0}, 32'h5A03_0100);
    send(0, 8'h53);
    expect_tx(0, "rd_s_b0", 8'h01);
    expect_tx(0, "rd_s_b1", 8'h00);
    settle();
    send(0, 8'h57); expect_tx(0, "rd_w", 8'h5A); settle();
    send(0, 8'h55); expect_tx(0, "bad_nak", 8'h3F); settle();
    check("bad_cfg", {width0, pulses0, spacing0}, 32'h5A03_0100);
    check("bad_delay", {16'd0, delay0}, 32'h1234);
    send(0, 8'h64); send(0, 8'hAB);
    expect_tx(0, "tmo_nak", 8'h3F);
    settle();
    check("tmo_delay", {16'd0, delay0}, 32'h1234);
    send(0, 8'h71); expect_tx(0, "status_tmo", 8'h02); settle();
    send(0, 8'h71); expect_tx(0, "status_clr", 8'h00); settle();
    t0 = trig_cnt;
    send(0, 8'h67); expect_tx(0, "fire_disarmed", 8'h3F); settle();
    check("no_trig", trig_cnt - t0, 32'd0);
    send(0, 8'h61); expect_tx(0, "arm_ack", 8'h6B); settle();
    check("armed", {31'd0, pen0}, 32'd1);
    t0 = trig_cnt;
    send(0, 8'h67);
    check("trig_high", {31'd0, trig0}, 32'd1);
    expect_tx(0, "fire_ack", 8'h6B);
    settle();
    check("trig_once", trig_cnt - t0, 32'd1);
    hold0 = 1'b1;
    send(0, 8'h44);
    send(0, 8'h77);
    repeat (3) @(negedge clk);
    hold0 = 1'b0;
    expect_tx(0, "ovr_rd_b0", 8'h12);
    expect_tx(0, "ovr_rd_b1", 8'h34);
    settle();
    send(0, 8'h71); expect_tx(0, "status_ovr", 8'h05); settle();
    q0.delete();
    send(0, 8'h64); send(0, 8'h99);
    rst_n = 1'b0;
    #1;
    check("rst_pay_cfg", {delay0, 14'd0, pen0, tx_en0}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_pay_quiet", q0.size(), 32'd0);
    hold0 = 1'b1;
    send(0, 8'h57);
    rst_n = 1'b0;
    #1;
    check("rst_rd_out", {width0, 7'd0, tx_en0, tx_data0}, 32'd0);
    hold0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_rd_quiet", q0.size(), 32'd0);
    send(1, 8'h64); send(1, 8'hDE); send(1, 8'hAD); send(1, 8'hBE);
    check("d32_partial", delay1, 32'd0);
    send(1, 8'hEF);
    check("d32_commit", delay1, 32'hDEAD_BEEF);
    expect_tx(1, "d32_ack", 8'h6B);
    settle();
    send(1, 8'h44);
    expect_tx(1, "d32_rd0", 8'hDE);
    expect_tx(1, "d32_rd1", 8'hAD);
    expect_tx(1, "d32_rd2", 8'hBE);
    expect_tx(1, "d32_rd3", 8'hEF);
    settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
